// File: rtl/pipeline_control_irq_return_seq.sv
// Interrupt-return sequencer: drains the pipeline, reloads P_RESTORE_NUM saved
// system registers from the interrupt stack frame and writes each one back.
module pipeline_control_irq_return_seq #(
  parameter int unsigned P_RESTORE_NUM = 3,
  parameter int unsigned P_IDX_W       = 2,
  parameter int unsigned P_WORD_STRIDE = 4
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iRESET_SYNC,
  input  logic               iRETURN_START,
  input  logic [31:0]        iFRAME_BASE,
  output logic               oBUSY,
  output logic               oFLUSH_REQ,
  input  logic               iFLUSH_DONE,
  output logic               oLDST_REQ,
  output logic [31:0]        oLDST_ADDR,
  input  logic               iLDST_BUSY,
  input  logic               iLDST_VALID,
  input  logic [31:0]        iLDST_DATA,
  output logic               oREG_WR_VALID,
  output logic [P_IDX_W-1:0] oREG_WR_INDEX,
  output logic [31:0]        oREG_WR_DATA,
  output logic               oFINISH
);

  // state   | meaning
  // S_IDLE  | waiting for a return request
  // S_FLUSH | pipeline drain requested, waiting for iFLUSH_DONE
  // S_REQ   | load request for word idx presented until accepted
  // S_WAIT  | load accepted, waiting for its data
  // S_DONE  | last word written, finish pulse
  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [P_IDX_W-1:0] LAST_IDX = P_IDX_W'(P_RESTORE_NUM - 1);
  localparam logic [31:0]        STRIDE   = 32'(P_WORD_STRIDE);

  if (P_RESTORE_NUM < 1 || P_RESTORE_NUM > (1 << P_IDX_W)) begin : g_bad_restore_num
    $error("P_RESTORE_NUM must lie in 1..2**P_IDX_W");
  end

  state_e             state_q, state_d;
  logic [P_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]        addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               flush_q, flush_d;
  logic               req_q, req_d;
  logic               wr_valid_q, wr_valid_d;
  logic [P_IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               finish_q, finish_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wr_valid_d = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (iRETURN_START) begin
          state_d = S_FLUSH;
          idx_d   = '0;
          addr_d  = iFRAME_BASE;
        end
      end
      S_FLUSH: if (iFLUSH_DONE) state_d = S_REQ;
      S_REQ:   if (!iLDST_BUSY) state_d = S_WAIT;
      S_WAIT: begin
        if (iLDST_VALID) begin
          wr_valid_d = 1'b1;
          wr_idx_d   = idx_q;
          wr_data_d  = iLDST_DATA;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            // running address avoids a multiplier; wraps naturally at 2^32
            idx_d   = idx_q + 1'b1;
            addr_d  = addr_q + STRIDE;
            state_d = S_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (iRESET_SYNC) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      addr_d     = '0;
      wr_valid_d = 1'b0;
      wr_idx_d   = '0;
      wr_data_d  = '0;
    end

    busy_d   = (state_d != S_IDLE);
    flush_d  = (state_d == S_FLUSH);
    req_d    = (state_d == S_REQ);
    finish_d = (state_d == S_DONE);
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      flush_q    <= 1'b0;
      req_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      flush_q    <= flush_d;
      req_q      <= req_d;
      wr_valid_q <= wr_valid_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      finish_q   <= finish_d;
    end
  end

  assign oBUSY         = busy_q;
  assign oFLUSH_REQ    = flush_q;
  assign oLDST_REQ     = req_q;
  assign oLDST_ADDR    = addr_q;
  assign oREG_WR_VALID = wr_valid_q;
  assign oREG_WR_INDEX = wr_idx_q;
  assign oREG_WR_DATA  = wr_data_q;
  assign oFINISH       = finish_q;

endmodule

// File: tb/tb_pipeline_control_irq_return_seq.sv
// Bench for the IRQ-return sequencer: a randomised load port and pipeline
// responder, checked against the frame-address and write-order rules.
module tb_pipeline_control_irq_return_seq;

  logic        clk, rst_n, rst_sync, start3, start1, flush_done, ldst_busy, ldst_valid;
  logic [31:0] frame, ldst_data;

  logic        b3, fr3, rq3, wv3, fn3;
  logic [31:0] ad3, wd3;
  logic [1:0]  wi3;
  logic        b1, fr1, rq1, wv1, fn1;
  logic [31:0] ad1, wd1;
  logic [0:0]  wi1;

  pipeline_control_irq_return_seq #(.P_RESTORE_NUM(3), .P_IDX_W(2), .P_WORD_STRIDE(4)) dut3 (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync), .iRETURN_START(start3),
    .iFRAME_BASE(frame), .oBUSY(b3), .oFLUSH_REQ(fr3), .iFLUSH_DONE(flush_done),
    .oLDST_REQ(rq3), .oLDST_ADDR(ad3), .iLDST_BUSY(ldst_busy), .iLDST_VALID(ldst_valid),
    .iLDST_DATA(ldst_data), .oREG_WR_VALID(wv3), .oREG_WR_INDEX(wi3), .oREG_WR_DATA(wd3),
    .oFINISH(fn3));

  pipeline_control_irq_return_seq #(.P_RESTORE_NUM(1), .P_IDX_W(1), .P_WORD_STRIDE(4)) dut1 (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync), .iRETURN_START(start1),
    .iFRAME_BASE(frame), .oBUSY(b1), .oFLUSH_REQ(fr1), .iFLUSH_DONE(flush_done),
    .oLDST_REQ(rq1), .oLDST_ADDR(ad1), .iLDST_BUSY(ldst_busy), .iLDST_VALID(ldst_valid),
    .iLDST_DATA(ldst_data), .oREG_WR_VALID(wv1), .oREG_WR_INDEX(wi1), .oREG_WR_DATA(wd1),
    .oFINISH(fn1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit          sel1;
  logic        o_busy, o_flush, o_req, o_wv, o_fin;
  logic [31:0] o_addr, o_wd;
  logic [1:0]  o_wi;

  always_comb begin
    o_busy  = sel1 ? b1  : b3;
    o_flush = sel1 ? fr1 : fr3;
    o_req   = sel1 ? rq1 : rq3;
    o_addr  = sel1 ? ad1 : ad3;
    o_wv    = sel1 ? wv1 : wv3;
    o_wi    = sel1 ? {1'b0, wi1} : wi3;
    o_wd    = sel1 ? wd1 : wd3;
    o_fin   = sel1 ? fn1 : fn3;
  end

  int checks = 0;
  int failures = 0;

  // Observations of one sequence, gathered by the port/pipeline responder.
  logic [31:0] acc_addr[$], sent_data[$], wr_data[$];
  int          wr_idx[$];
  int fin_cnt, fin_ok, fin_cyc, fc, overlap_err, stall_err, w1_req, post_active, abort_active;
  bit timed_out;

  task automatic run_seq(input logic [31:0] base, input int nwords, input int fdelay,
                         input int busy_pct, input int lat_max, input bit noise,
                         input bit dir_data, input int stall_len, input int abort_word);
    int cyc = 0, cnt = 0, tail = 0, abort_ph = 0, stall_left = stall_len;
    bit pending = 0, fin_seen = 0, aborting = 0, done = 0, prev_req = 0, prev_busy = 0;
    logic [31:0] prev_addr = '0, d;
    acc_addr.delete(); sent_data.delete(); wr_data.delete(); wr_idx.delete();
    fin_cnt = 0; fin_ok = 0; fin_cyc = -1; fc = 0; overlap_err = 0; stall_err = 0;
    w1_req = 0; post_active = 0; abort_active = 0; timed_out = 0;
    @(negedge clk);
    if (sel1) start1 = 1'b1; else start3 = 1'b1;
    frame = base;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0; frame = $urandom;
    cyc = 1;
    while (!done) begin
      if (fin_seen && !aborting) begin
        if (o_busy || o_flush || o_req || o_wv || o_fin) post_active++;
        tail++;
        if (tail >= 3) done = 1;
      end
      if (o_wv) begin wr_idx.push_back(int'(o_wi)); wr_data.push_back(o_wd); end
      if (o_fin) begin
        fin_cnt++; fin_cyc = cyc; fin_seen = 1;
        if (o_wv && int'(o_wi) == nwords - 1) fin_ok++;
      end
      if (o_flush) fc++;
      if (o_flush && o_req) overlap_err++;
      if (prev_req && prev_busy && (!o_req || o_addr !== prev_addr)) stall_err++;
      if (o_req && acc_addr.size() == 1) w1_req++;
      if (aborting) begin
        abort_ph++;
        if (o_busy || o_flush || o_req || o_addr != 0 || o_wv || o_wi != 0 || o_wd != 0 || o_fin)
          abort_active++;
        if (abort_ph >= 5) done = 1;
      end

      rst_sync = 1'b0; ldst_valid = 1'b0; ldst_data = $urandom; flush_done = 1'b0; ldst_busy = 1'b0;
      start1 = 1'b0; start3 = 1'b0;
      if (aborting) begin
        if (abort_ph == 1) ldst_valid = 1'b1;   // late data for the aborted load
      end else if (abort_word >= 0 && pending && acc_addr.size() == abort_word + 1) begin
        rst_sync = 1'b1; aborting = 1;
      end else begin
        if (pending) begin
          if (cnt == 0) begin
            d = dir_data ? 32'hA + 32'(sent_data.size()) : $urandom;
            ldst_valid = 1'b1; ldst_data = d; sent_data.push_back(d); pending = 0;
          end else cnt--;
        end else if (noise && $urandom_range(3) == 0) ldst_valid = 1'b1;
        if (o_flush) flush_done = (fc > fdelay);
        else if (noise) flush_done = 1'($urandom_range(1));
        if (o_req) begin
          if (acc_addr.size() == 1 && stall_left > 0) begin ldst_busy = 1'b1; stall_left--; end
          else ldst_busy = ($urandom_range(99) < busy_pct);
          if (!ldst_busy) begin
            acc_addr.push_back(o_addr); pending = 1; cnt = int'($urandom_range(lat_max));
          end
        end else if (noise) ldst_busy = 1'($urandom_range(1));
        if (noise && o_busy && !fin_seen) begin
          if (sel1) start1 = o_flush ? 1'b1 : 1'($urandom_range(1));
          else      start3 = o_flush ? 1'b1 : 1'($urandom_range(1));
        end
      end
      prev_req = o_req; prev_busy = ldst_busy; prev_addr = o_addr;
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin timed_out = 1; done = 1; end
    end
    rst_sync = 1'b0; ldst_valid = 1'b0; flush_done = 1'b0; ldst_busy = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_sync = 1'b0; start3 = 1'b0; start1 = 1'b0; frame = 32'h1234_5678;
    flush_done = 1'b0; ldst_busy = 1'b0; ldst_valid = 1'b0; ldst_data = '0; sel1 = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({b3, fr3, rq3, wv3, fn3} !== 5'b0)
      begin failures++; $display("FAIL reset_ctrl3 got=%b exp=00000", {b3, fr3, rq3, wv3, fn3}); end
    checks++;
    if (ad3 !== 32'h0 || wi3 !== 2'h0 || wd3 !== 32'h0)
      begin failures++; $display("FAIL reset_data3 addr=%h idx=%h data=%h exp=0", ad3, wi3, wd3); end
    checks++;
    if ({b1, fr1, rq1, wv1, fn1} !== 5'b0 || ad1 !== 32'h0 || wd1 !== 32'h0)
      begin failures++; $display("FAIL reset_dut1 ctrl=%b addr=%h exp=0", {b1, fr1, rq1, wv1, fn1}, ad1); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (b3 !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b exp=0", b3); end
  endtask

  task automatic test_zero_wait();
    sel1 = 0;
    run_seq(32'h0000_1000, 3, 0, 0, 0, 0, 1, 0, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL zw_timeout got=1 exp=0"); end
    checks++;
    if (acc_addr.size() != 3) begin failures++; $display("FAIL zw_loads got=%0d exp=3", acc_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc_addr[i] !== 32'h1000 + 32'(4 * i))
        begin failures++; $display("FAIL zw_addr%0d got=%h exp=%h", i, acc_addr[i], 32'h1000 + 32'(4 * i)); end
    end
    checks++;
    if (wr_idx.size() != 3) begin failures++; $display("FAIL zw_writes got=%0d exp=3", wr_idx.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_idx[i] != i || wr_data[i] !== 32'hA + 32'(i))
        begin failures++; $display("FAIL zw_write%0d got=%0d/%h exp=%0d/%h", i, wr_idx[i], wr_data[i], i, 32'hA + 32'(i)); end
    end
    checks++;
    if (fin_cnt != 1 || fin_ok != 1)
      begin failures++; $display("FAIL zw_finish count=%0d with_last=%0d exp=1/1", fin_cnt, fin_ok); end
    // start cycle plus eight more cycles: nine cycles to the finish pulse
    checks++;
    if (fin_cyc != 8) begin failures++; $display("FAIL zw_latency got=%0d exp=8", fin_cyc); end
    checks++;
    if (post_active != 0) begin failures++; $display("FAIL zw_busy_drop got=%0d exp=0", post_active); end
  endtask

  task automatic test_stall();
    sel1 = 0;
    run_seq(32'h0000_1000, 3, 0, 0, 0, 0, 1, 3, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL stall_timeout got=1 exp=0"); end
    checks++;
    if (w1_req != 4) begin failures++; $display("FAIL stall_req_cycles got=%0d exp=4", w1_req); end
    checks++;
    if (stall_err != 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stall_err); end
    checks++;
    if (acc_addr.size() != 3 || acc_addr[1] !== 32'h1004)
      begin failures++; $display("FAIL stall_loads n=%0d exp=3 addr1 exp=00001004", acc_addr.size()); end
    checks++;
    if (wr_idx.size() != 3) begin failures++; $display("FAIL stall_writes got=%0d exp=3", wr_idx.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_idx[i] != i || wr_data[i] !== 32'hA + 32'(i))
        begin failures++; $display("FAIL stall_write%0d got=%0d/%h exp=%0d/%h", i, wr_idx[i], wr_data[i], i, 32'hA + 32'(i)); end
    end
    checks++;
    if (fin_cnt != 1 || fin_ok != 1)
      begin failures++; $display("FAIL stall_finish count=%0d with_last=%0d exp=1/1", fin_cnt, fin_ok); end
  endtask

  task automatic test_flush_delay();
    sel1 = 0;
    run_seq($urandom, 3, 5, 0, 1, 1, 0, 0, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL fd_timeout got=1 exp=0"); end
    checks++;
    if (fc != 6) begin failures++; $display("FAIL fd_flush_cycles got=%0d exp=6", fc); end
    checks++;
    if (overlap_err != 0) begin failures++; $display("FAIL fd_req_during_flush got=%0d exp=0", overlap_err); end
    checks++;
    if (fin_cnt != 1 || fin_ok != 1 || wr_idx.size() != 3 || acc_addr.size() != 3)
      begin failures++; $display("FAIL fd_single_seq fin=%0d writes=%0d loads=%0d exp=1/3/3", fin_cnt, wr_idx.size(), acc_addr.size()); end
    checks++;
    if (post_active != 0) begin failures++; $display("FAIL fd_no_extra_seq got=%0d exp=0", post_active); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a[3];
    exp_a[0] = 32'hFFFF_FFFC; exp_a[1] = 32'h0000_0000; exp_a[2] = 32'h0000_0004;
    sel1 = 0;
    run_seq(32'hFFFF_FFFC, 3, 1, 30, 2, 0, 0, 0, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL wrap_timeout got=1 exp=0"); end
    checks++;
    if (acc_addr.size() != 3) begin failures++; $display("FAIL wrap_loads got=%0d exp=3", acc_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc_addr[i] !== exp_a[i])
        begin failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, acc_addr[i], exp_a[i]); end
    end
    checks++;
    if (wr_idx.size() != 3 || sent_data.size() != 3)
      begin failures++; $display("FAIL wrap_writes got=%0d exp=3", wr_idx.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_idx[i] != i || wr_data[i] !== sent_data[i])
        begin failures++; $display("FAIL wrap_write%0d got=%0d/%h exp=%0d/%h", i, wr_idx[i], wr_data[i], i, sent_data[i]); end
    end
  endtask

  task automatic test_reset_mid();
    sel1 = 0;
    run_seq(32'h0000_2000, 3, 0, 20, 2, 0, 0, 0, 1);
    checks++; if (timed_out) begin failures++; $display("FAIL abort_timeout got=1 exp=0"); end
    checks++;
    if (abort_active != 0) begin failures++; $display("FAIL abort_outputs_zero got=%0d exp=0", abort_active); end
    checks++;
    if (wr_idx.size() != 1 || fin_cnt != 0 || acc_addr.size() != 2)
      begin failures++; $display("FAIL abort_effects writes=%0d fin=%0d loads=%0d exp=1/0/2", wr_idx.size(), fin_cnt, acc_addr.size()); end
    run_seq(32'h0000_3000, 3, 1, 0, 1, 0, 1, 0, -1);
    checks++;
    if (wr_idx.size() != 3 || fin_cnt != 1 || fin_ok != 1 || timed_out)
      begin failures++; $display("FAIL abort_restart writes=%0d fin=%0d exp=3/1", wr_idx.size(), fin_cnt); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_idx[i] != i || wr_data[i] !== 32'hA + 32'(i) || acc_addr[i] !== 32'h3000 + 32'(4 * i))
        begin failures++; $display("FAIL abort_restart_word%0d got=%0d/%h/%h", i, wr_idx[i], wr_data[i], acc_addr[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] base;
    sel1 = 0;
    for (int n = 0; n < 25; n++) begin
      base = $urandom;
      run_seq(base, 3, int'($urandom_range(3)), int'($urandom_range(50)), int'($urandom_range(3)), 1, 0, 0, -1);
      checks++;
      if (timed_out || fin_cnt != 1 || fin_ok != 1 || post_active != 0 || overlap_err != 0 || stall_err != 0)
        begin failures++; $display("FAIL rnd%0d_ctrl to=%0d fin=%0d/%0d post=%0d ovl=%0d stall=%0d exp=0/1/1/0/0/0", n, timed_out, fin_cnt, fin_ok, post_active, overlap_err, stall_err); end
      checks++;
      if (acc_addr.size() != 3 || wr_idx.size() != 3 || sent_data.size() != 3)
        begin failures++; $display("FAIL rnd%0d_counts loads=%0d writes=%0d exp=3/3", n, acc_addr.size(), wr_idx.size()); end
      else for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_addr[i] !== base + 32'(4 * i) || wr_idx[i] != i || wr_data[i] !== sent_data[i])
          begin failures++; $display("FAIL rnd%0d_word%0d addr=%h exp=%h idx=%0d data=%h exp=%h", n, i, acc_addr[i], base + 32'(4 * i), wr_idx[i], wr_data[i], sent_data[i]); end
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] base;
    int spurious = 0;
    sel1 = 1;
    for (int i = 0; i < 4; i++) begin
      ldst_valid = 1'b1; ldst_data = $urandom;
      @(negedge clk);
      if (wv1 || b1) spurious++;
    end
    ldst_valid = 1'b0;
    @(negedge clk);
    if (wv1 || b1) spurious++;
    checks++;
    if (spurious != 0) begin failures++; $display("FAIL n1_idle_valid got=%0d exp=0", spurious); end
    base = $urandom;
    run_seq(base, 1, 2, 30, 2, 0, 0, 0, -1);
    checks++;
    if (timed_out || acc_addr.size() != 1 || wr_idx.size() != 1 || sent_data.size() != 1)
      begin failures++; $display("FAIL n1_counts to=%0d loads=%0d writes=%0d exp=0/1/1", timed_out, acc_addr.size(), wr_idx.size()); end
    else begin
      checks++;
      if (acc_addr[0] !== base || wr_idx[0] != 0 || wr_data[0] !== sent_data[0])
        begin failures++; $display("FAIL n1_word addr=%h exp=%h idx=%0d data=%h exp=%h", acc_addr[0], base, wr_idx[0], wr_data[0], sent_data[0]); end
    end
    checks++;
    if (fin_cnt != 1 || fin_ok != 1 || post_active != 0)
      begin failures++; $display("FAIL n1_finish count=%0d with_write=%0d post=%0d exp=1/1/0", fin_cnt, fin_ok, post_active); end
    sel1 = 0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_flush_delay();
    test_wrap();
    test_reset_mid();
    test_random();
    test_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_control_irq_return_seq.md
Name: pipeline_control_irq_return_seq

Overview:
- Parametrised successor to the single-step IRQ-return controller.
- On an interrupt return it drains the pipeline, then reloads P_RESTORE_NUM saved system registers (PSR, PC, SPR, ...) from the interrupt stack frame over the load/store port.
- Each reloaded word is written back to the system-register file, then a one-cycle finish pulse is raised.
- Sits in pipeline_control beside the IRQ-call sequencer.

Parameters:
P_RESTORE_NUM, 3, number of 32-bit words restored, legal 1..2^P_IDX_W; 0 is an elaboration error
P_IDX_W, 2, width of the register-index counter/output
P_WORD_STRIDE, 4, byte distance between consecutive frame words

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iRESET_SYNC  in  1  synchronous reset, same effect as inRESET, takes priority over all other inputs
iRETURN_START  in  1  one-cycle return request
iFRAME_BASE  in  32  frame base address, sampled with iRETURN_START
oBUSY  out  1  sequence in progress (state != IDLE)
oFLUSH_REQ  out  1  pipeline drain request, level
iFLUSH_DONE  in  1  pipeline drained
oLDST_REQ  out  1  load request, level until accepted
oLDST_ADDR  out  32  load address
iLDST_BUSY  in  1  port cannot accept; request accepted on a cycle with oLDST_REQ=1 and iLDST_BUSY=0
iLDST_VALID  in  1  load data valid
iLDST_DATA  in  32  load data
oREG_WR_VALID  out  1  one-cycle system-register write strobe
oREG_WR_INDEX  out  P_IDX_W  register index 0..P_RESTORE_NUM-1
oREG_WR_DATA  out  32  register write data
oFINISH  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, iCLOCK. inRESET is asynchronous and active-low.
- Reset values (inRESET low or iRESET_SYNC high): state IDLE, idx=0, base=0, all outputs 0.
- All outputs are registered.
- States: IDLE, FLUSH, REQ, WAIT, DONE.
- IDLE:
  - iRETURN_START=1 -> capture base=iFRAME_BASE, idx=0, go to FLUSH.
  - oFLUSH_REQ=1 from the next cycle.
- FLUSH:
  - oFLUSH_REQ held at 1.
  - On iFLUSH_DONE=1 -> drop oFLUSH_REQ and go to REQ.
  - oLDST_REQ=1 and oLDST_ADDR=base+idx*P_WORD_STRIDE (mod 2^32) from the next cycle.
- REQ:
  - oLDST_REQ and oLDST_ADDR held stable while iLDST_BUSY=1.
  - On acceptance -> oLDST_REQ=0 next cycle, go to WAIT.
- WAIT:
  - On iLDST_VALID=1, the next cycle gives oREG_WR_VALID=1, oREG_WR_INDEX=idx, oREG_WR_DATA=iLDST_DATA (latched).
  - If idx==P_RESTORE_NUM-1 -> go to DONE; otherwise idx+1 and go to REQ.
  - Minimum of 1 cycle per word between acceptance and the next request.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - oFINISH=1 for exactly the cycle state==DONE; this coincides with the final oREG_WR_VALID.
- Ignored inputs:
  - iRETURN_START while not IDLE; it is not queued.
  - iLDST_VALID outside WAIT.
  - iFLUSH_DONE outside FLUSH.
- iFLUSH_DONE already high on FLUSH entry -> FLUSH lasts one cycle.
- Address arithmetic wraps modulo 2^32; there is no error on wrap.
- Reset mid-sequence:
  - Aborts immediately; no further oREG_WR_VALID or oFINISH.
  - Any load already accepted by the port has its data ignored.
- Latency, zero-wait port, N=3: start->FINISH = 1 (FLUSH entry) + 1 (flush) + 3x(REQ+WAIT) + 1 = 9 cycles minimum.

Test Plan:
- Zero-wait, N=3, iFRAME_BASE=0x0000_1000, data 0xA,0xB,0xC, flush done immediately -> addrs 0x1000/0x1004/0x1008; writes idx0=0xA, idx1=0xB, idx2=0xC; single oFINISH with the idx2 write; oBUSY then drops.
- iLDST_BUSY held 3 cycles on the second request -> oLDST_ADDR stays 0x1004 and oLDST_REQ stays high through the stall; exactly one acceptance; write order unchanged.
- iFLUSH_DONE delayed 5 cycles -> oFLUSH_REQ high 5+ cycles and no oLDST_REQ meanwhile; second iRETURN_START during FLUSH -> no extra sequence.
- iFRAME_BASE=0xFFFF_FFFC, N=3 -> addrs 0xFFFFFFFC, 0x00000000, 0x00000004.
- iRESET_SYNC pulse in WAIT of word 1, with a late iLDST_VALID after it -> all outputs 0, state IDLE, no write, no oFINISH; a fresh start afterwards completes normally.
- P_RESTORE_NUM=1 build -> one load, one write at idx 0, oFINISH in the same cycle; spurious iLDST_VALID while in IDLE -> no oREG_WR_VALID.
